uart_rx: RTL and testbench

Asynchronous serial receiver, the receive-side counterpart of the `UartTx` transmitter, sharing its frame format and run-time configuration.
- Frame: start bit, 8 data bits LSB first, optional odd/even parity bit, one or two stop bits.
- Samples each bit at its midpoint, checks parity and stop bits, and presents one byte per frame with a single-cycle valid strobe and error flags.
- Sits between the board pin (via its own synchronizer) and the host-side byte interface.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_t     - receiver FSM states
//   UART_DATA_BITS      - data bits per frame
//   UART_RX_MIN_DIVIDER - smallest usable bit period in clocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_rx_state_t;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_RX_MIN_DIVIDER = 4;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: STAGES-flop synchronizer for an asynchronous single-bit input.
// Flops reset to 1 so an idle (high) serial line reads idle straight out of reset.
//   clock, reset : clock and synchronous active-high reset
//   d            : asynchronous input
//   q            : synchronized output, STAGES cycles behind d
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clock) begin
        if (reset) ff <= '1;
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver. Frame = start, 8 data bits LSB first,
// optional odd/even parity, one or two stop bits. Each bit is sampled at its
// midpoint; one byte per frame is presented with a one-cycle valid strobe.
//
// Ports:
//   clock_i, reset_i      : clock, synchronous active-high reset
//   serial_i              : asynchronous serial line (idles high)
//   clock_divider_i       : bit period N in clocks, values < 4 act as 4
//   two_stop_bits_i       : check a second stop bit
//   parity_bit_i          : frame carries a parity bit
//   parity_even_i         : 1 = even, 0 = odd parity
//   data_o, valid_o       : received byte and its one-cycle strobe
//   parity_error_o        : parity mismatch in the last frame
//   framing_error_o       : a stop bit sampled low in the last frame
//   busy_o                : frame in progress (through the valid cycle)
//
// Build option: UART_RX_MAJORITY_VOTE_EN - each sample becomes a 3-sample
// majority vote around the nominal point, taken one cycle later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        serial_i,
    input  logic [15:0] clock_divider_i,
    input  logic        two_stop_bits_i,
    input  logic        parity_bit_i,
    input  logic        parity_even_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        parity_error_o,
    output logic        framing_error_o,
    output logic        busy_o
);

    localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);
    localparam logic [15:0] MIN_DIV  = 16'(UART_RX_MIN_DIVIDER);

    uart_rx_state_t state_q, state_d;

    logic                      rx_s;
    logic [SYNC_STAGES-1:0]    fill_q;
    logic                      rx_armed;
    logic [15:0]               cnt_q;
    logic [15:0]               div_q;
    logic                      two_stop_q;
    logic                      par_en_q;
    logic                      par_even_q;
    logic [2:0]                idx_q;
    logic [UART_DATA_BITS-1:0] shreg_q;
    logic                      par_err_q;
    logic                      frm_err_q;

    logic [15:0] div_clamped;
    logic [15:0] start_load;
    logic        start_edge;
    logic        tick;
    logic        bit_val;
    logic        par_exp;
    logic        done;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock_i),
        .reset (reset_i),
        .d     (serial_i),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Two cycles of history: the vote is taken one cycle after the nominal
    // sample point, so the start delay is one cycle longer and every later
    // sample inherits that shift through the N-cycle reloads.
    logic rx_d1, rx_d2;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val    = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
    assign start_load = (div_clamped >> 1) + 16'd1;
`else
    assign bit_val    = rx_s;
    assign start_load = div_clamped >> 1;
`endif

    assign div_clamped = (clock_divider_i < MIN_DIV) ? MIN_DIV : clock_divider_i;
    // rx_armed is only set once rx_s has been seen high after the synchronizer
    // has flushed, so a line held low through reset (or after a break) never
    // looks like a start edge.
    assign start_edge  = rx_armed & ~rx_s;
    assign tick        = (cnt_q == 16'd1);
    assign par_exp     = par_even_q ? ^shreg_q : ~^shreg_q;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE:   if (start_edge) state_d = START;
            START:  if (tick) state_d = bit_val ? IDLE : DATA;
            DATA:   if (tick && idx_q == LAST_IDX) state_d = par_en_q ? PARITY : STOP1;
            PARITY: if (tick) state_d = STOP1;
            STOP1:  if (tick) begin
                        state_d = two_stop_q ? STOP2 : IDLE;
                        done    = ~two_stop_q;
                    end
            STOP2:  if (tick) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            fill_q          <= '0;
            rx_armed        <= 1'b0;
            cnt_q           <= '0;
            div_q           <= MIN_DIV;
            two_stop_q      <= 1'b0;
            par_en_q        <= 1'b0;
            par_even_q      <= 1'b0;
            idx_q           <= '0;
            shreg_q         <= '0;
            par_err_q       <= 1'b0;
            frm_err_q       <= 1'b0;
            data_o          <= 8'h00;
            valid_o         <= 1'b0;
            parity_error_o  <= 1'b0;
            framing_error_o <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_o  <= done;
            // Held through the valid cycle even though the FSM is already idle.
            busy_o   <= (state_d != IDLE) || done;
            fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            rx_armed <= rx_s & fill_q[SYNC_STAGES-1];

            if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;

            case (state_q)
                IDLE: if (start_edge) begin
                    cnt_q      <= start_load;
                    div_q      <= div_clamped;
                    two_stop_q <= two_stop_bits_i;
                    par_en_q   <= parity_bit_i;
                    par_even_q <= parity_even_i;
                    idx_q      <= '0;
                    par_err_q  <= 1'b0;
                    frm_err_q  <= 1'b0;
                end
                // A reload on a false start is harmless: IDLE ignores the counter.
                START: if (tick) cnt_q <= div_q;
                DATA: if (tick) begin
                    shreg_q[idx_q] <= bit_val;
                    idx_q          <= idx_q + 3'd1;
                    cnt_q          <= div_q;
                end
                PARITY: if (tick) begin
                    par_err_q <= (bit_val != par_exp);
                    cnt_q     <= div_q;
                end
                STOP1, STOP2: if (tick) begin
                    if (!bit_val) frm_err_q <= 1'b1;
                    cnt_q <= div_q;
                end
                default: ;
            endcase

            // The final stop sample is folded in directly since frm_err_q
            // has not absorbed it yet.
            if (done) begin
                data_o          <= shreg_q;
                parity_error_o  <= par_err_q;
                framing_error_o <= frm_err_q | ~bit_val;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A bit-level transmitter drives
// frames; the expected byte, flags and valid cycle of each frame are computed
// from the frame format and the sample-point arithmetic, and compared with
// the strobes captured by a monitor.
module tb_uart_rx;

    localparam int SYNC = 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        serial_i = 1'b1;
    logic [15:0] clock_divider_i = 16'd16;
    logic        two_stop_bits_i = 1'b0;
    logic        parity_bit_i = 1'b0;
    logic        parity_even_i = 1'b0;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        parity_error_o;
    logic        framing_error_o;
    logic        busy_o;

    uart_rx #(.SYNC_STAGES(SYNC)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .serial_i        (serial_i),
        .clock_divider_i (clock_divider_i),
        .two_stop_bits_i (two_stop_bits_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .parity_error_o  (parity_error_o),
        .framing_error_o (framing_error_o),
        .busy_o          (busy_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } frame_t;

    frame_t got_q[$];
    frame_t exp_q[$];
    int     cyc = 0;
    int     dbl_valid = 0;
    int     busy_rise = -1;
    logic   valid_prev = 1'b0;
    logic   busy_prev = 1'b0;
    int     n_chk = 0;
    int     n_fail = 0;

    always @(posedge clock_i) cyc <= cyc + 1;

    always @(negedge clock_i) begin
        if (valid_o) got_q.push_back('{data_o, parity_error_o, framing_error_o, cyc});
        if (valid_o && valid_prev) dbl_valid <= dbl_valid + 1;
        if (busy_o && !busy_prev) busy_rise <= cyc;
        valid_prev <= valid_o;
        busy_prev  <= busy_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        serial_i = b;
        tick(n);
    endtask

    function automatic frame_t get_frame(input int i);
        frame_t f;
        f = '{8'hxx, 1'bx, 1'bx, -1};
        if (i < got_q.size()) f = got_q[i];
        return f;
    endfunction

    // Transmit one frame and queue what the receiver must report for it.
    // Config inputs are scrambled after the start bit: they must already be latched.
    task automatic send_frame(input logic [7:0] d, input int n_cfg, input bit pen, input bit peven,
                              input bit pflip, input bit ts, input bit [1:0] slow, input int gap);
        int   n;
        int   s;
        logic pbit;
        n = (n_cfg < 4) ? 4 : n_cfg;
        clock_divider_i = 16'(n_cfg);
        two_stop_bits_i = ts;
        parity_bit_i    = pen;
        parity_even_i   = peven;
        s = cyc;
        drive_bit(1'b0, n);
        clock_divider_i = 16'($urandom);
        two_stop_bits_i = 1'($urandom);
        parity_bit_i    = 1'($urandom);
        parity_even_i   = 1'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        pbit = (peven ? ^d : ~^d) ^ pflip;
        if (pen) drive_bit(pbit, n);
        drive_bit(~slow[0], n);
        if (ts) drive_bit(~slow[1], n);
        serial_i = 1'b1;
        exp_q.push_back('{d, pen & pflip, slow[0] | (ts & slow[1]),
                          s + SYNC + (n >> 1) + (9 + int'(pen) + int'(ts)) * n + 1 + MV});
        tick(gap);
    endtask

    task automatic test_reset;
        serial_i = 1'b1;
        reset_i  = 1'b1;
        tick(4);
        reset_i = 1'b0;
        tick(1);
        n_chk++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_o); end
        n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_chk++; if (parity_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", parity_error_o); end
        n_chk++; if (framing_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", framing_error_o); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        tick(4);
    endtask

    task automatic test_basic;
        frame_t g;
        int     dv;
        got_q.delete(); exp_q.delete();
        dv = dbl_valid;
        send_frame(8'hA5, 16, 0, 0, 0, 0, 2'b00, 16);
        g = get_frame(0);
        n_chk++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", got_q.size()); end
        n_chk++; if (g.d !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h want a5", g.d); end
        n_chk++; if ({g.pe, g.fe} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b want 00", {g.pe, g.fe}); end
        n_chk++; if (g.cyc !== exp_q[0].cyc) begin n_fail++; $display("FAIL basic_valid_cycle got %0d want %0d", g.cyc, exp_q[0].cyc); end
        n_chk++; if (dbl_valid !== dv) begin n_fail++; $display("FAIL basic_valid_width got %0d want %0d", dbl_valid, dv); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy_o); end
    endtask

    task automatic test_parity;
        frame_t g;
        for (int r = 0; r < 2; r++) begin
            got_q.delete(); exp_q.delete();
            send_frame(8'h55, 16, 1, 0, r[0], 0, 2'b00, 0);
            send_frame(8'hAA, 16, 1, 1, r[0], 0, 2'b00, 20);
            n_chk++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL parity_count r%0d got %0d want 2", r, got_q.size()); end
            for (int i = 0; i < 2; i++) begin
                g = get_frame(i);
                n_chk++;
                if ({g.d, g.pe, g.fe, g.cyc} !== {exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc}) begin
                    n_fail++;
                    $display("FAIL parity_frame r%0d f%0d got d=%h pe=%b fe=%b cyc=%0d want d=%h pe=%b fe=%b cyc=%0d",
                             r, i, g.d, g.pe, g.fe, g.cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
                end
            end
        end
        n_chk++; if (parity_error_o !== 1'b1) begin n_fail++; $display("FAIL parity_flag_hold got %b want 1", parity_error_o); end
    endtask

    task automatic test_two_stop;
        frame_t g;
        got_q.delete(); exp_q.delete();
        send_frame(8'h3C, 16, 0, 0, 0, 1, 2'b10, 16);
        g = get_frame(0);
        n_chk++; if (g.d !== 8'h3C) begin n_fail++; $display("FAIL stop2_data got %h want 3c", g.d); end
        n_chk++; if (g.fe !== 1'b1) begin n_fail++; $display("FAIL stop2_ferr got %b want 1", g.fe); end
        n_chk++; if (g.cyc !== exp_q[0].cyc) begin n_fail++; $display("FAIL stop2_valid_cycle got %0d want %0d", g.cyc, exp_q[0].cyc); end
        n_chk++; if (framing_error_o !== 1'b1) begin n_fail++; $display("FAIL stop2_ferr_hold got %b want 1", framing_error_o); end
        send_frame(8'h5A, 16, 0, 0, 0, 1, 2'b00, 16);
        g = get_frame(1);
        n_chk++; if ({g.d, g.fe} !== {8'h5A, 1'b0}) begin n_fail++; $display("FAIL stop2_clear got d=%h fe=%b want d=5a fe=0", g.d, g.fe); end
    endtask

    task automatic test_glitch;
        frame_t g;
        int     s;
        got_q.delete(); exp_q.delete();
        clock_divider_i = 16'd16;
        s = cyc;
        serial_i = 1'b0;
        tick(2);
        serial_i = 1'b1;
        tick(40);
        n_chk++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_valid got %0d want 0", got_q.size()); end
        n_chk++; if (busy_rise !== s + SYNC + 1) begin n_fail++; $display("FAIL glitch_busy_rise got %0d want %0d", busy_rise, s + SYNC + 1); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_after got %b want 0", busy_o); end
        send_frame(8'h81, 16, 0, 0, 0, 0, 2'b00, 16);
        g = get_frame(0);
        n_chk++; if ({g.d, g.pe, g.fe} !== {8'h81, 2'b00}) begin n_fail++; $display("FAIL glitch_next got d=%h pe=%b fe=%b want d=81 pe=0 fe=0", g.d, g.pe, g.fe); end
    endtask

    task automatic test_reset_mid;
        frame_t     g;
        logic [7:0] part;
        got_q.delete(); exp_q.delete();
        part = 8'h6B;
        clock_divider_i = 16'd16;
        two_stop_bits_i = 1'b0;
        parity_bit_i    = 1'b0;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(part[i], 16);
        reset_i = 1'b1;
        tick(1);
        n_chk++; if ({data_o, valid_o, parity_error_o, framing_error_o, busy_o} !== 12'h000)
            begin n_fail++; $display("FAIL rstmid_outputs got d=%h v=%b pe=%b fe=%b b=%b want all 0",
                                      data_o, valid_o, parity_error_o, framing_error_o, busy_o); end
        serial_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
        tick(200);
        n_chk++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_valid got %0d want 0", got_q.size()); end
        send_frame(8'h0F, 16, 0, 0, 0, 0, 2'b00, 16);
        g = get_frame(0);
        n_chk++; if ({g.d, g.pe, g.fe} !== {8'h0F, 2'b00}) begin n_fail++; $display("FAIL rstmid_next got d=%h pe=%b fe=%b want d=0f pe=0 fe=0", g.d, g.pe, g.fe); end
    endtask

    task automatic test_min_div;
        frame_t g;
        int     s;
        got_q.delete(); exp_q.delete();
        s = cyc;
        send_frame(8'hC3, 2, 0, 0, 0, 0, 2'b00, 8);
        g = get_frame(0);
        n_chk++; if (g.d !== 8'hC3) begin n_fail++; $display("FAIL mindiv_data got %h want c3", g.d); end
        n_chk++; if (g.cyc !== s + 41 + MV) begin n_fail++; $display("FAIL mindiv_valid_cycle got %0d want %0d", g.cyc, s + 41 + MV); end
        n_chk++; if (busy_rise !== s + SYNC + 1) begin n_fail++; $display("FAIL mindiv_busy_rise got %0d want %0d", busy_rise, s + SYNC + 1); end
    endtask

    task automatic test_break;
        frame_t g;
        int     s;
        got_q.delete(); exp_q.delete();
        clock_divider_i = 16'd8;
        two_stop_bits_i = 1'b0;
        parity_bit_i    = 1'b0;
        s = cyc;
        serial_i = 1'b0;
        tick(30 * 8);
        g = get_frame(0);
        n_chk++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL break_count got %0d want 1", got_q.size()); end
        n_chk++; if ({g.d, g.fe} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL break_frame got d=%h fe=%b want d=00 fe=1", g.d, g.fe); end
        n_chk++; if (g.cyc !== s + SYNC + 4 + 72 + 1 + MV) begin n_fail++; $display("FAIL break_valid_cycle got %0d want %0d", g.cyc, s + SYNC + 77 + MV); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL break_busy got %b want 0", busy_o); end
        serial_i = 1'b1;
        tick(8);
        send_frame(8'h7E, 8, 0, 0, 0, 0, 2'b00, 8);
        g = get_frame(1);
        n_chk++; if ({g.d, g.fe} !== {8'h7E, 1'b0}) begin n_fail++; $display("FAIL break_next got d=%h fe=%b want d=7e fe=0", g.d, g.fe); end
    endtask

    task automatic test_random;
        frame_t   g;
        int       n;
        bit [1:0] slow;
        int       gap;
        got_q.delete(); exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            n    = $urandom_range(0, 20);
            slow = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            gap  = (slow != 2'b00) ? 20 : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30));
            send_frame(8'($urandom), n, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), slow, gap);
        end
        tick(40);
        n_chk++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = get_frame(i);
            n_chk++;
            if ({g.d, g.pe, g.fe, g.cyc} !== {exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc}) begin
                n_fail++;
                $display("FAIL random_frame %0d got d=%h pe=%b fe=%b cyc=%0d want d=%h pe=%b fe=%b cyc=%0d",
                         i, g.d, g.pe, g.fe, g.cyc, exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_glitch();
        test_reset_mid();
        test_min_div();
        test_break();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
